// File: rtl/imu_rd_ctrl_if.sv
// Handshake bundle between the IMU read controller, the SPI transceiver
// and the inertial integrator.
interface imu_rd_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] roll_rt;
    logic [15:0] yaw_rt;
    logic [15:0] ax;
    logic [15:0] ay;

    modport master (
        output wrt, cmd, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
        input  done, rd_data
    );

    modport slave (
        input  wrt, cmd, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
        output done, rd_data
    );
endinterface

// File: rtl/imu_rd_ctrl.sv
// IMU read controller: configures the IMU over SPI after power-up, then reads
// ten byte registers per data-ready interrupt into five signed 16-bit readings.
module imu_rd_ctrl #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          INT,
    imu_rd_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        READ,
        DONE
    } state_t;

    localparam logic [7:0] RD_BASE = 8'hA2;
    localparam logic [3:0] LAST_IDX = 4'd9;

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hold_q [10];
    logic [7:0]  hold_d [10];
    logic        int_ff1_q, int_s_q;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        vld_q, vld_d;
    logic [15:0] ptch_q, ptch_d;
    logic [15:0] roll_q, roll_d;
    logic [15:0] yaw_q, yaw_d;
    logic [15:0] ax_q, ax_d;
    logic [15:0] ay_q, ay_d;
    logic        pwr_done;

    // Only the low byte of each transceiver read carries register data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.rd_data[15:8];

    assign pwr_done = FAST_SIM ? (&tmr_q[8:0]) : (&tmr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1_q <= 1'b0;
            int_s_q   <= 1'b0;
        end else begin
            int_ff1_q <= INT;
            int_s_q   <= int_ff1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            tmr_q   <= '0;
            idx_q   <= '0;
            for (int unsigned i = 0; i < 10; i++) begin
                hold_q[i] <= '0;
            end
            wrt_q   <= 1'b0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            for (int unsigned i = 0; i < 10; i++) begin
                hold_q[i] <= hold_d[i];
            end
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 16'd1;
        idx_d   = idx_q;
        hold_d  = hold_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        ax_d    = ax_q;
        ay_d    = ay_q;

        unique case (state_q)
            PWR_WAIT: begin
                if (pwr_done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h0D02;
                    state_d = INIT1;
                end
            end
            INIT1: begin
                if (bus.done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h1062;
                    state_d = INIT2;
                end
            end
            INIT2: begin
                if (bus.done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h1162;
                    state_d = INIT3;
                end
            end
            INIT3: begin
                if (bus.done) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h1460;
                    state_d = INIT4;
                end
            end
            INIT4: begin
                if (bus.done) begin
                    state_d = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (int_s_q) begin
                    wrt_d   = 1'b1;
                    cmd_d   = {RD_BASE, 8'h00};
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.done) begin
                    hold_d[idx_q] = bus.rd_data[7:0];
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        wrt_d = 1'b1;
                        cmd_d = {RD_BASE + {4'h0, idx_q} + 8'd1, 8'h00};
                    end
                end
            end
            DONE: begin
                // All five readings and vld update on the same edge.
                vld_d   = 1'b1;
                ptch_d  = {hold_q[1], hold_q[0]};
                roll_d  = {hold_q[3], hold_q[2]};
                yaw_d   = {hold_q[5], hold_q[4]};
                ax_d    = {hold_q[7], hold_q[6]};
                ay_d    = {hold_q[9], hold_q[8]};
                state_d = WAIT_INT;
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    assign bus.wrt     = wrt_q;
    assign bus.cmd     = cmd_q;
    assign bus.vld     = vld_q;
    assign bus.ptch_rt = ptch_q;
    assign bus.roll_rt = roll_q;
    assign bus.yaw_rt  = yaw_q;
    assign bus.ax      = ax_q;
    assign bus.ay      = ay_q;

endmodule

// File: tb/tb_imu_rd_ctrl.sv
// Directed bench for imu_rd_ctrl: SPI responder model with fixed 20-clock
// latency, command log, and checks of init order, read data, timing and reset.
module tb_imu_rd_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic INT = 1'b0;

    always #5 clk = ~clk;

    imu_rd_ctrl_if bus();

    imu_rd_ctrl #(.FAST_SIM(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .INT  (INT),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  resp [10];
    logic [15:0] log_cmd [$];
    int          log_cyc [$];

    int   vld_pulses = 0;
    int   vld_hi = 0;
    int   last_vld_cyc = -10;
    int   done_cyc = 0;
    int   vld_lat = 0;
    int   b2b = 0;
    int   cmd_err = 0;
    int   ovl_err = 0;
    logic vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] q_at(input int i);
        return (i < log_cmd.size()) ? log_cmd[i] : 16'hDEAD;
    endfunction

    // SPI transceiver model: one outstanding transaction, done 20 clks after wrt.
    initial begin : responder
        logic        busy;
        logic [15:0] pend;
        int          cnt;
        logic [7:0]  a;
        bus.done    = 1'b0;
        bus.rd_data = '0;
        busy = 1'b0;
        pend = '0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                vld_prev = 1'b0;
            end else begin
                if (busy && bus.cmd !== pend) cmd_err++;
                if (bus.wrt) begin
                    if (busy) ovl_err++;
                    busy = 1'b1;
                    pend = bus.cmd;
                    cnt  = 20;
                    log_cmd.push_back(bus.cmd);
                    log_cyc.push_back(cyc);
                    if (bus.cmd == 16'hA200 && last_vld_cyc == cyc - 1) b2b++;
                end else if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 1'b0;
                        a = pend[15:8] - 8'hA2;
                        bus.done    = 1'b1;
                        bus.rd_data = {8'hEE, (a < 8'd10) ? resp[a[3:0]] : 8'h00};
                        done_cyc    = cyc;
                    end
                end
                if (bus.vld) begin
                    vld_hi++;
                    if (!vld_prev) begin
                        vld_pulses++;
                        vld_lat = cyc - done_cyc;
                        last_vld_cyc = cyc;
                    end
                end
                vld_prev = bus.vld;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_int(input int n);
        INT = 1'b1;
        repeat (n) @(posedge clk);
        INT = 1'b0;
    endtask

    task automatic wait_pulses(input int target);
        for (int k = 0; k < 5000 && vld_pulses < target; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 3000 && log_cmd.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input logic [7:0] base);
        for (int i = 0; i < 10; i++) resp[i] = base + 8'(i);
    endtask

    initial begin : main
        int rel;
        int p0;
        int h0;
        int b0;
        int np;
        logic [15:0] init_tab [4];
        init_tab[0] = 16'h0D02;
        init_tab[1] = 16'h1062;
        init_tab[2] = 16'h1162;
        init_tab[3] = 16'h1460;
        for (int i = 0; i < 10; i++) resp[i] = 8'h11 * 8'(i + 1);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wrt",  32'(bus.wrt), 32'd0);
        chk("rst_vld",  32'(bus.vld), 32'd0);
        chk("rst_cmd",  32'(bus.cmd), 32'd0);
        chk("rst_ptch", 32'(bus.ptch_rt), 32'd0);
        chk("rst_ay",   32'(bus.ay), 32'd0);

        // Power-up wait and init sequence
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_log(4);
        chk("init_count", 32'(log_cmd.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("init_cmd", 32'(q_at(i)), 32'(init_tab[i]));
        chk("pwr_latency", 32'(log_cyc[0] - rel), 32'd512);
        repeat (300) @(posedge clk);
        #1;
        chk("no_wrt_before_int", 32'(log_cmd.size()), 32'd4);

        // Single read with bytes 11..AA
        log_cmd.delete();
        log_cyc.delete();
        p0 = vld_pulses;
        h0 = vld_hi;
        pulse_int(3);
        wait_pulses(p0 + 1);
        chk("rd1_wrt_count", 32'(log_cmd.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("rd1_addr", 32'(q_at(i)), 32'({8'hA2 + 8'(i), 8'h00}));
        chk("rd1_ptch", 32'(bus.ptch_rt), 32'h2211);
        chk("rd1_roll", 32'(bus.roll_rt), 32'h4433);
        chk("rd1_yaw",  32'(bus.yaw_rt),  32'h6655);
        chk("rd1_ax",   32'(bus.ax),      32'h8877);
        chk("rd1_ay",   32'(bus.ay),      32'hAA99);
        chk("rd1_vld_latency", 32'(vld_lat), 32'd2);
        repeat (100) @(posedge clk);
        #1;
        chk("rd1_one_pulse", 32'(vld_pulses - p0), 32'd1);
        chk("rd1_vld_width", 32'(vld_hi - h0), 32'd1);
        chk("rd1_hold_ptch", 32'(bus.ptch_rt), 32'h2211);

        // Signed extremes
        resp[0] = 8'hFF;
        resp[1] = 8'hFF;
        resp[2] = 8'h00;
        resp[3] = 8'h80;
        p0 = vld_pulses;
        pulse_int(3);
        wait_pulses(p0 + 1);
        chk("sgn_ptch", 32'(bus.ptch_rt), 32'hFFFF);
        chk("sgn_roll", 32'(bus.roll_rt), 32'h8000);
        chk("sgn_yaw",  32'(bus.yaw_rt),  32'h6655);

        // INT pulsed again mid-read is ignored
        set_resp(8'h31);
        log_cmd.delete();
        log_cyc.delete();
        p0 = vld_pulses;
        pulse_int(3);
        wait_log(5);
        pulse_int(3);
        wait_pulses(p0 + 1);
        repeat (300) @(posedge clk);
        #1;
        chk("midint_pulses", 32'(vld_pulses - p0), 32'd1);
        chk("midint_wrts",   32'(log_cmd.size()), 32'd10);
        chk("midint_ptch",   32'(bus.ptch_rt), 32'h3231);
        chk("midint_ay",     32'(bus.ay),      32'h3A39);

        // Back-to-back reads with INT held high
        set_resp(8'h41);
        log_cmd.delete();
        log_cyc.delete();
        p0 = vld_pulses;
        b0 = b2b;
        INT = 1'b1;
        repeat (700) @(posedge clk);
        INT = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        np = vld_pulses - p0;
        chk("b2b_at_least_3", 32'(np >= 3), 32'd1);
        chk("b2b_gap_one_clk", 32'(b2b - b0), 32'(np - 1));
        chk("b2b_wrt_count", 32'(log_cmd.size()), 32'(10 * np));
        chk("b2b_yaw", 32'(bus.yaw_rt), 32'h4645);
        chk("cmd_stable", 32'(cmd_err), 32'd0);
        chk("no_overlap", 32'(ovl_err), 32'd0);

        // Reset during byte 6 of a read
        set_resp(8'h51);
        log_cmd.delete();
        log_cyc.delete();
        pulse_int(3);
        wait_log(7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_ptch", 32'(bus.ptch_rt), 32'd0);
        chk("mrst_ax",   32'(bus.ax), 32'd0);
        chk("mrst_cmd",  32'(bus.cmd), 32'd0);
        chk("mrst_wrt",  32'(bus.wrt), 32'd0);
        repeat (2) @(negedge clk);
        log_cmd.delete();
        log_cyc.delete();
        rst_n = 1'b1;
        rel = cyc;
        wait_log(4);
        for (int i = 0; i < 4; i++) chk("reinit_cmd", 32'(q_at(i)), 32'(init_tab[i]));
        chk("reinit_latency", 32'(log_cyc[0] - rel), 32'd512);
        repeat (200) @(posedge clk);
        p0 = vld_pulses;
        pulse_int(3);
        wait_pulses(p0 + 1);
        chk("post_rst_ptch", 32'(bus.ptch_rt), 32'h5251);
        chk("post_rst_ay",   32'(bus.ay),      32'h5A59);
        chk("post_rst_wrts", 32'(log_cmd.size()), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
